ofmap_reader: RTL and testbench

OFMAP_READER -- requirements
Module: ofmap_reader

---
 rtl/ofmap_reader_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/ofmap_reader.sv | 132 +++++++++++++
 tb/tb_ofmap_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_reader_pkg.sv
// Shared memory map, FSM encodings and address helper for the ofmap readout path.
// Imported by ofmap_reader.
package ofmap_reader_pkg;

  localparam int PARAM_BASE = 0;
  localparam int WTS_BASE   = 64;
  localparam int IFMAP_BASE = 65536;
  localparam int OFMAP_BASE = 131072;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_READ  = 4'b0010;
  localparam logic [3:0] ST_DRAIN = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  // Ofmap words are laid out channel-major, then row, then column.
  function automatic logic [17:0] ofmap_offset(input logic [3:0] c,
                                               input logic [4:0] y,
                                               input logic [4:0] x);
    return {4'd0, c, y, x};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an occupancy count.
// Its read data is combinational from the head entry.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_reader.sv
// Streams an ofmap out of DRAM through a small credit-limited FIFO.
// A read is only issued when its returning word is guaranteed a FIFO slot.
module ofmap_reader
  import ofmap_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [5:0]            num_chnl,
  input  logic [5:0]            ofmap_width,
  input  logic [5:0]            ofmap_height,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]            state;
  logic [5:0]            x_cnt, y_cnt, c_cnt;
  logic [5:0]            num_chnl_r, width_r, height_r;
  logic                  inflight;
  logic [13:0]           out_cnt, last_idx;
  logic [17:0]           total_words;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty, fifo_full;
  logic                  pop, zero_dim, issue_last, drain_done;

  assign zero_dim    = (num_chnl == '0) || (ofmap_width == '0) || (ofmap_height == '0);
  assign total_words = 18'(num_chnl) * 18'(ofmap_height) * 18'(ofmap_width);
  assign occupancy   = {1'b0, fifo_count} + (CW+1)'(inflight);

  assign dram_en_rd = (state == ST_READ) && !fifo_full &&
                      (occupancy < (CW+1)'(FIFO_DEPTH));
  assign addr_rd    = dram_en_rd ?
                      ADDR_WIDTH'(OFMAP_BASE) +
                      ADDR_WIDTH'(ofmap_offset(c_cnt[3:0], y_cnt[4:0], x_cnt[4:0])) : '0;

  assign issue_last = (x_cnt == width_r - 6'd1) && (y_cnt == height_r - 6'd1) &&
                      (c_cnt == num_chnl_r - 6'd1);
  assign pop        = dout_valid && dout_ready;
  // Look one pop ahead so done follows the last accepted word immediately.
  assign drain_done = !inflight &&
                      (fifo_empty || ((fifo_count == CW'(1)) && pop));

  assign dout_valid = !fifo_empty;
  assign dout       = fifo_empty ? '0 : fifo_dout;
  assign dout_last  = dout_valid && (out_cnt == last_idx);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start) begin
      num_chnl_r <= num_chnl;
      width_r    <= ofmap_width;
      height_r   <= ofmap_height;
      last_idx   <= 14'(total_words - 18'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= ST_IDLE;
      x_cnt    <= '0;
      y_cnt    <= '0;
      c_cnt    <= '0;
      inflight <= 1'b0;
      out_cnt  <= '0;
    end else begin
      inflight <= dram_en_rd;
      if (pop) out_cnt <= out_cnt + 14'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            c_cnt   <= '0;
            out_cnt <= '0;
            state   <= zero_dim ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (dram_en_rd) begin
            if (x_cnt == width_r - 6'd1) begin
              x_cnt <= '0;
              if (y_cnt == height_r - 6'd1) begin
                y_cnt <= '0;
                c_cnt <= c_cnt + 6'd1;
              end else begin
                y_cnt <= y_cnt + 6'd1;
              end
            end else begin
              x_cnt <= x_cnt + 6'd1;
            end
            if (issue_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (drain_done) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (srst),
    .push  (inflight),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ofmap_reader.sv
// Directed bench for ofmap_reader with a DRAM model and address/word scoreboards.
module tb_ofmap_reader;

  localparam int OFMAP_BASE_TB = 131072;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num_chnl = '0, ofmap_width = '0, ofmap_height = '0;
  logic        dram_en_rd;
  logic [17:0] addr_rd;
  logic [31:0] data_in = '0;
  logic [31:0] dout;
  logic        dout_valid, dout_ready = 1'b0, dout_last, busy, done;

  logic [17:0] addr_q[$];
  logic [31:0] word_q[$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, rd_cnt = 0, words_out = 0, done_cnt = 0;
  int last_cyc = -1, done_cyc = -1;
  logic [17:0] last_addr = '0;
  logic        hold = 1'b0;
  logic [31:0] hold_word = '0;

  ofmap_reader dut (
    .clk (clk), .srst (srst), .start (start), .num_chnl (num_chnl),
    .ofmap_width (ofmap_width), .ofmap_height (ofmap_height),
    .dram_en_rd (dram_en_rd), .addr_rd (addr_rd), .data_in (data_in),
    .dout (dout), .dout_valid (dout_valid), .dout_ready (dout_ready),
    .dout_last (dout_last), .busy (busy), .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [17:0] a);
    return 32'hA5000000 ^ {14'd0, a} ^ ({14'd0, a} << 13);
  endfunction

  // DRAM returns the addressed word exactly one cycle after the request.
  always @(posedge clk) data_in <= dram_en_rd ? memWord(addr_rd) : 32'h0BAD0BAD;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (srst) begin
      hold = 1'b0;
    end else begin
      if (dram_en_rd) begin
        rd_cnt++;
        last_addr = addr_rd;
        checkOutput("read_expected", 32'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) checkOutput("addr_rd", 32'(addr_rd), 32'(addr_q.pop_front()));
      end else begin
        checkOutput("addr_idle_zero", 32'(addr_rd), 0);
      end
      if (hold) begin
        checkOutput("hold_valid", 32'(dout_valid), 1);
        checkOutput("hold_data", dout, hold_word);
      end
      if (dout_valid && dout_ready) begin
        words_out++;
        checkOutput("word_expected", 32'(word_q.size() != 0), 1);
        if (word_q.size() != 0) begin
          checkOutput("dout", dout, word_q.pop_front());
          checkOutput("dout_last", 32'(dout_last), 32'(word_q.size() == 0));
        end
        if (dout_last) last_cyc = cyc;
      end
      hold      = dout_valid && !dout_ready;
      hold_word = dout;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic applyStimulus(input int n, input int w, input int h);
    num_chnl     = 6'(n);
    ofmap_width  = 6'(w);
    ofmap_height = 6'(h);
    for (int c = 0; c < n; c++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          logic [17:0] a;
          a = 18'(OFMAP_BASE_TB + c * 1024 + y * 32 + x);
          addr_q.push_back(a);
          word_q.push_back(memWord(a));
        end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    checkOutput("done_seen", 32'(seen), 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_en"},    32'(dram_en_rd), 0);
    checkOutput({tag, "_addr"},  32'(addr_rd), 0);
    checkOutput({tag, "_valid"}, 32'(dout_valid), 0);
    checkOutput({tag, "_last"},  32'(dout_last), 0);
    checkOutput({tag, "_busy"},  32'(busy), 0);
    checkOutput({tag, "_done"},  32'(done), 0);
    checkOutput({tag, "_dout"},  dout, 0);
  endtask

  initial begin
    int rd0, dc0;
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd0, dc0;
    repeat (3) @(posedge clk);
    #1 checkIdleOutputs("reset");
    srst = 1'b0;

    $display("[TB] basic readout 2ch 2x2");
    dout_ready = 1'b1; words_out = 0; rd0 = rd_cnt;
    applyStimulus(2, 2, 2);
    checkOutput("basic_busy", 32'(busy), 1);
    checkOutput("basic_valid_c1", 32'(dout_valid), 0);
    @(posedge clk); #1 checkOutput("basic_valid_c2", 32'(dout_valid), 0);
    @(posedge clk); #1 checkOutput("basic_valid_c3", 32'(dout_valid), 1);
    waitDone(100);
    checkOutput("basic_words", 32'(words_out), 8);
    checkOutput("basic_reads", 32'(rd_cnt - rd0), 8);
    checkOutput("basic_done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
    checkOutput("basic_throughput", 32'(done_cyc), 32'(start_cyc + 10));
    checkOutput("basic_q_empty", 32'(word_q.size() + addr_q.size()), 0);
    @(posedge clk); #1 checkOutput("basic_done_width", 32'(done), 0);
    checkOutput("basic_busy_end", 32'(busy), 0);

    $display("[TB] backpressure 1ch 4x4");
    dout_ready = 1'b0; words_out = 0; rd0 = rd_cnt;
    applyStimulus(1, 4, 4);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("bp_reads_stalled", 32'(rd_cnt - rd0), 4);
    checkOutput("bp_en_low", 32'(dram_en_rd), 0);
    checkOutput("bp_valid", 32'(dout_valid), 1);
    dout_ready = 1'b1;
    waitDone(200);
    checkOutput("bp_words", 32'(words_out), 16);
    checkOutput("bp_q_empty", 32'(word_q.size() + addr_q.size()), 0);

    $display("[TB] zero dimension");
    @(posedge clk); #1;
    rd0 = rd_cnt;
    applyStimulus(3, 0, 4);
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_en", 32'(dram_en_rd), 0);
    @(posedge clk); #1 checkOutput("zero_done_width", 32'(done), 0);
    checkOutput("zero_busy_end", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1 checkOutput("zero_no_reads", 32'(rd_cnt - rd0), 0);

    $display("[TB] start while busy");
    dout_ready = 1'b1; words_out = 0; rd0 = rd_cnt;
    applyStimulus(1, 4, 2);
    num_chnl = 6'd3; ofmap_width = 6'd5; ofmap_height = 6'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waitDone(100);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("sb_words", 32'(words_out), 8);
    checkOutput("sb_reads", 32'(rd_cnt - rd0), 8);
    checkOutput("sb_busy_end", 32'(busy), 0);

    $display("[TB] reset mid-stream");
    dout_ready = 1'b0; words_out = 0;
    applyStimulus(1, 4, 4);
    repeat (4) @(posedge clk);
    #1 checkOutput("rst_pre_valid", 32'(dout_valid), 1);
    srst = 1'b1;
    @(posedge clk); #1 checkIdleOutputs("rst_mid");
    srst = 1'b0;
    addr_q.delete();
    word_q.delete();
    @(posedge clk); #1 checkOutput("rst_discard_inflight", 32'(dout_valid), 0);
    dout_ready = 1'b1;
    applyStimulus(2, 3, 2);
    waitDone(100);
    checkOutput("rst_new_words", 32'(words_out), 12);
    checkOutput("rst_q_empty", 32'(word_q.size() + addr_q.size()), 0);

    $display("[TB] maximum row 16ch 32x1, random ready");
    @(posedge clk); #1;
    words_out = 0; dc0 = done_cnt;
    applyStimulus(16, 32, 1);
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1 dout_ready = 1'($urandom_range(0, 1));
      if (done_cnt != dc0) break;
    end
    dout_ready = 1'b1;
    checkOutput("max_done", 32'(done_cnt - dc0), 1);
    checkOutput("max_words", 32'(words_out), 512);
    checkOutput("max_final_addr", 32'(last_addr), 146463);
    checkOutput("max_q_empty", 32'(word_q.size() + addr_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
